// File: rtl/io_register_controller.sv
// CPU register-bus peripheral block: decodes register accesses into a UART
// transmitter fed by a TX FIFO, an LED latch, a status register and a cycle counter.
module io_register_controller #(
  parameter int CLOCKS_PER_BIT = 16,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx,
  output logic [7:0]  leds,
  output logic        tx_overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [PTR_W:0]    COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_req;
  logic              push;
  logic              pop;

  tx_state_t         state;
  tx_state_t         state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_next;
  logic [2:0]        bit_index;
  logic [2:0]        bit_next;
  logic [7:0]        shift;
  logic [7:0]        shift_next;
  logic              tx_next;

  logic [15:0]       cycle_count;
  logic [15:0]       read_data;

  assign fifo_full  = (count == COUNT_FULL);
  assign fifo_empty = (count == '0);
  assign push_req   = register_write && (register_index == 12'd0);
  assign push       = push_req && !fifo_full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= register_write_value[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_index <= '0;
      shift     <= '0;
      uart_tx   <= 1'b1;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_index <= bit_next;
      shift     <= shift_next;
      uart_tx   <= tx_next;
    end
  end

  // STOP pops on its last cycle so back-to-back frames have no idle gap
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + 1'b1;
    bit_next   = bit_index;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr];
          state_next = START;
        end
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next  = '0;
          bit_next   = 3'd0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next = '0;
          if (bit_index == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_index + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level is computed from the next state and registered, so the pin never glitches
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_next];
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  always_comb begin
    read_data = '0;
    case (register_index)
      12'd1:   read_data = {13'b0, tx_overflow, fifo_full, fifo_empty};
      12'd2:   read_data = {8'b0, leds};
      12'd3:   read_data = cycle_count;
      default: read_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      register_read_value <= '0;
      leds                <= '0;
      tx_overflow         <= 1'b0;
      cycle_count         <= '0;
    end else begin
      if (register_read) begin
        register_read_value <= read_data;
      end
      if (register_write && (register_index == 12'd2)) begin
        leds <= register_write_value[7:0];
      end
      if (push_req && fifo_full) begin
        tx_overflow <= 1'b1;
      end else if (register_write && (register_index == 12'd1) && register_write_value[0]) begin
        tx_overflow <= 1'b0;
      end
      if (register_write && (register_index == 12'd3)) begin
        cycle_count <= register_write_value;
      end else begin
        cycle_count <= cycle_count + 1'b1;
      end
    end
  end

endmodule
